instr_fetch_stage: RTL and testbench

PC-generation and fetch stage of the single-issue MIPS core. It drives the address of the combinational instruction memory and captures the returned word with its PC. Captured words go into a small FIFO, which feeds decode through a valid/ready handshake. It accepts redirects (branch/jump/jr) from downstream and halts after fetching a syscall.

---
 rtl/instr_fetch_stage.sv | 126 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// PC generation and fetch buffer for the single-issue MIPS core; stops fetching after a syscall.
// Optional build macro FETCH_PERF_CNT_EN adds fetched/stall performance counters.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] SYSCALL_WORD = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        halted
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // state    | meaning
    // ST_RUN   | fetching one word per cycle when the buffer has room
    // ST_HALT  | syscall fetched; PC frozen until redirect or reset
    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [31:0]    pc_q;
    logic [31:0]    pc_mem    [FIFO_DEPTH];
    logic [31:0]    instr_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic           pop;
    logic           push;
    logic           redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign out_valid = (count != '0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    assign pop  = out_valid & out_ready;
    assign push = !halted && !redirect_valid && ((count < CW'(FIFO_DEPTH)) || pop);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (push && (imem_instr == SYSCALL_WORD)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (redirect_valid) begin
                // Flush wins over any concurrent handshake; the head is dropped, not consumed.
                pc_q   <= {redirect_pc[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]    <= pc_q;
                    instr_mem[wr_ptr] <= imem_instr;
                    wr_ptr            <= wr_ptr + PW'(1);
                    pc_q              <= pc_q + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!halted && !redirect_valid && !push) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized scoreboard bench for instr_fetch_stage against a queue-based fetch model.
module tb_instr_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] SYSCALL  = 32'h0000_000C;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int syscall_idx = -1;
    bit started = 1'b0;

    ent_t        exp_q[$];
    int          mcount = 0;
    logic [31:0] mpc = RST_PC;
    bit          mhalt = 1'b0;
    logic [31:0] mperf_f = '0;
    logic [31:0] mperf_s = '0;

    always #5 clk = ~clk;

    instr_fetch_stage #(
        .RESET_PC    (RST_PC),
        .FIFO_DEPTH  (DEPTH),
        .SYSCALL_WORD(SYSCALL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall),
`endif
        .halted        (halted)
    );

    // Memory image: word k holds k+0x100, except one optional syscall slot.
    function automatic logic [31:0] word_of(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (syscall_idx >= 0 && idx == 32'(syscall_idx)) return SYSCALL;
        return idx + 32'h100;
    endfunction

    always_comb imem_instr = word_of(imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference model: advances on every rising edge from the inputs presented before it.
    always @(posedge clk) begin
        bit pop_m;
        bit push_m;
        logic [31:0] w;
        if (rst) begin
            exp_q.delete();
            mcount  = 0;
            mpc     = RST_PC;
            mhalt   = 1'b0;
            mperf_f = '0;
            mperf_s = '0;
        end else if (redirect_valid) begin
            exp_q.delete();
            mcount = 0;
            mpc    = redirect_pc & 32'hFFFF_FFFC;
            mhalt  = 1'b0;
        end else begin
            pop_m  = (mcount > 0) && out_ready;
            push_m = !mhalt && ((mcount < DEPTH) || pop_m);
            if (push_m) begin
                w = word_of(mpc);
                exp_q.push_back('{pc: mpc, instr: w});
                mpc = mpc + 32'd4;
                if (w == SYSCALL) mhalt = 1'b1;
                mperf_f = mperf_f + 32'd1;
            end else if (!mhalt) begin
                mperf_s = mperf_s + 32'd1;
            end
            mcount = mcount + int'(push_m) - int'(pop_m);
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each accepted handshake.
    always @(negedge clk) begin
        ent_t e;
        if (started) begin
            check32("imem_addr", imem_addr, mpc);
            check32("halted", 32'(halted), 32'(mhalt));
            check32("out_valid", 32'(out_valid), 32'(mcount > 0));
`ifdef FETCH_PERF_CNT_EN
            check32("perf_fetched", perf_fetched, mperf_f);
            check32("perf_stall", perf_stall, mperf_s);
`endif
            if (out_valid && out_ready && !redirect_valid && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual_pc=0x%08h required=none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("out_pc", out_pc, e.pc);
                    check32("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    task automatic step(input logic rdy, input logic rv, input logic [31:0] rp, input logic rs);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        rst            = rs;
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_out_instr", out_instr, 32'd0);
        check32("rst_out_pc", out_pc, 32'd0);
        check32("rst_imem_addr", imem_addr, RST_PC);
        check32("rst_halted", 32'(halted), 32'd0);
        started = 1'b1;

        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);

        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
        check32("bp_hold_addr", imem_addr, 32'h8);
        check32("bp_head_pc", out_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h2E, 1'b0);
        check32("redir_addr", imem_addr, 32'h2C);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

        syscall_idx = 6;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0, 1'b0);
        check32("sys_hold_addr", imem_addr, 32'h1C);
        check32("sys_halted", 32'(halted), 32'd1);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check32("midrst_addr", imem_addr, RST_PC);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) syscall_idx = int'($urandom_range(0, 63));
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0,
                 32'($urandom_range(0, 255)),
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
